// File: rtl/audio_ctrl.sv
// Transport controller for the audio codec: button pulses -> stop/record/fast/slow/rate/interp.
// Optional macro AUDIO_CTRL_AUTOLOOP_EN: playback loops through REWIND instead of ending in IDLE.
module audio_ctrl #(
  parameter int MAX_SPEED = 7
) (
  input  logic        AUD_BCLK,
  input  logic        rst_n,
  input  logic        btn_record,
  input  logic        btn_play,
  input  logic        btn_stop,
  input  logic        btn_faster,
  input  logic        btn_slower,
  input  logic        interp_sw,
  input  logic        AUD_DACLRCK,
  input  logic [17:0] address,
  output logic        stop,
  output logic        record,
  output logic        fast,
  output logic        slow,
  output logic        interp,
  output logic [3:0]  rate,
  output logic [17:0] end_addr,
  output logic [1:0]  state,
  output logic        done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REC    = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
`ifdef AUDIO_CTRL_AUTOLOOP_EN
  localparam logic [1:0] ST_REWIND = 2'd3;
`endif

  localparam logic signed [3:0] SPD_MAX = 4'(MAX_SPEED);
  localparam logic signed [3:0] SPD_MIN = -SPD_MAX;

  function automatic logic signed [3:0] spd_step(input logic signed [3:0] cur,
                                                 input logic up, input logic dn);
    spd_step = cur;
    if (up && !dn && (cur < SPD_MAX))
      spd_step = cur + 4'sd1;
    else if (dn && !up && (cur > SPD_MIN))
      spd_step = cur - 4'sd1;
  endfunction

  function automatic logic [3:0] spd_rate(input logic signed [3:0] s);
    logic signed [3:0] mag;
    mag      = (s < 4'sd0) ? -s : s;
    spd_rate = $unsigned(mag) + 4'd1;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [17:0]        end_addr_q, end_addr_d;
  logic               done_q, done_d;
  logic               rec_pend_q, rec_pend_d;
  logic signed [3:0]  spd_q, spd_d;
  logic signed [3:0]  spd_pend_q, spd_pend_d;
  logic               lrck_q, lrck_prev_q;
  logic               stop_q, stop_d;
  logic               record_q, record_d;
  logic               fast_q, fast_d;
  logic               slow_q, slow_d;
  logic               interp_q, interp_d;
  logic [3:0]         rate_q, rate_d;

  // Transport FSM; PLAY->REC is deferred one IDLE cycle via rec_pend so stop clears the codec address
  always_comb begin
    state_d    = state_q;
    end_addr_d = end_addr_q;
    done_d     = 1'b0;
    rec_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_stop)
          state_d = ST_IDLE;
        else if (btn_record || rec_pend_q)
          state_d = ST_REC;
        else if (btn_play && (end_addr_q != 18'd0))
          state_d = ST_PLAY;
      end
      ST_REC: begin
        if (btn_stop || (address == 18'h3FFFF)) begin
          state_d    = ST_IDLE;
          end_addr_d = address;
        end
      end
      ST_PLAY: begin
        if (btn_stop) begin
          state_d = ST_IDLE;
        end else if (address >= end_addr_q) begin
          done_d = 1'b1;
`ifdef AUDIO_CTRL_AUTOLOOP_EN
          state_d = ST_REWIND;
`else
          state_d = ST_IDLE;
`endif
        end else if (btn_record) begin
          state_d    = ST_IDLE;
          rec_pend_d = 1'b1;
        end
      end
`ifdef AUDIO_CTRL_AUTOLOOP_EN
      ST_REWIND: state_d = btn_stop ? ST_IDLE : ST_PLAY;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Speed: pending level accumulates presses, committed mid-frame on lrck rising
  always_comb begin
    spd_pend_d = spd_step(spd_pend_q, btn_faster, btn_slower);
    spd_d      = (lrck_q && !lrck_prev_q) ? spd_pend_q : spd_q;
    stop_d     = (state_d != ST_REC) && (state_d != ST_PLAY);
    record_d   = (state_d == ST_REC);
    fast_d     = (spd_d > 4'sd0);
    slow_d     = (spd_d < 4'sd0);
    rate_d     = spd_rate(spd_d);
    interp_d   = interp_sw && slow_d;
  end

  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      end_addr_q  <= 18'd0;
      done_q      <= 1'b0;
      rec_pend_q  <= 1'b0;
      spd_q       <= 4'sd0;
      spd_pend_q  <= 4'sd0;
      lrck_q      <= 1'b0;
      lrck_prev_q <= 1'b0;
      stop_q      <= 1'b1;
      record_q    <= 1'b0;
      fast_q      <= 1'b0;
      slow_q      <= 1'b0;
      interp_q    <= 1'b0;
      rate_q      <= 4'd1;
    end else begin
      state_q     <= state_d;
      end_addr_q  <= end_addr_d;
      done_q      <= done_d;
      rec_pend_q  <= rec_pend_d;
      spd_q       <= spd_d;
      spd_pend_q  <= spd_pend_d;
      lrck_q      <= AUD_DACLRCK;
      lrck_prev_q <= lrck_q;
      stop_q      <= stop_d;
      record_q    <= record_d;
      fast_q      <= fast_d;
      slow_q      <= slow_d;
      interp_q    <= interp_d;
      rate_q      <= rate_d;
    end
  end

  assign stop     = stop_q;
  assign record   = record_q;
  assign fast     = fast_q;
  assign slow     = slow_q;
  assign interp   = interp_q;
  assign rate     = rate_q;
  assign end_addr = end_addr_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_audio_ctrl.sv
// Directed bench for audio_ctrl; expectations follow AUDIO_CTRL_AUTOLOOP_EN when defined.
module tb_audio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_record, btn_play, btn_stop, btn_faster, btn_slower;
  logic        interp_sw, lrck;
  logic [17:0] address;
  logic        stop, record, fast, slow, interp, done;
  logic [3:0]  rate;
  logic [17:0] end_addr;
  logic [1:0]  state;

  int nvec = 0;
  int nerr = 0;

  audio_ctrl #(.MAX_SPEED(7)) dut (
    .AUD_BCLK(clk), .rst_n(rst_n),
    .btn_record(btn_record), .btn_play(btn_play), .btn_stop(btn_stop),
    .btn_faster(btn_faster), .btn_slower(btn_slower),
    .interp_sw(interp_sw), .AUD_DACLRCK(lrck), .address(address),
    .stop(stop), .record(record), .fast(fast), .slow(slow), .interp(interp),
    .rate(rate), .end_addr(end_addr), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b = {stop, record, play, faster, slower}
  task automatic press(input logic [4:0] b);
    {btn_stop, btn_record, btn_play, btn_faster, btn_slower} = b;
    step();
    {btn_stop, btn_record, btn_play, btn_faster, btn_slower} = 5'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    if (stop !== 1'b1) begin nerr++; $display("FAIL reset_stop: got %b want 1", stop); end
    nvec++;
    if (rate !== 4'd1) begin nerr++; $display("FAIL reset_rate: got %0d want 1", rate); end
    nvec++;
    if (state !== 2'd0) begin nerr++; $display("FAIL reset_state: got %0d want 0", state); end
    nvec++;
    if (end_addr !== 18'd0) begin nerr++; $display("FAIL reset_end_addr: got %h want 0", end_addr); end
    nvec++;
    if ({record, fast, slow, interp, done} !== 5'b0) begin
      nerr++; $display("FAIL reset_ctrls: got %b want 00000", {record, fast, slow, interp, done});
    end
    nvec++;
    press(5'b00100);
    if (state !== 2'd0) begin nerr++; $display("FAIL play_empty: got %0d want 0", state); end
    nvec++;
  endtask

  task automatic test_record_play();
    press(5'b01000);
    if (state !== 2'd1 || record !== 1'b1 || stop !== 1'b0) begin
      nerr++; $display("FAIL rec_enter: state %0d rec %b stop %b want 1 1 0", state, record, stop);
    end
    nvec++;
    address = 18'h00080;
    step();
    address = 18'h00100;
    press(5'b10000);
    if (state !== 2'd0 || record !== 1'b0 || stop !== 1'b1) begin
      nerr++; $display("FAIL rec_stop: state %0d rec %b stop %b want 0 0 1", state, record, stop);
    end
    nvec++;
    if (end_addr !== 18'h00100) begin nerr++; $display("FAIL rec_end_addr: got %h want 00100", end_addr); end
    nvec++;
    address = 18'h0;
    press(5'b00100);
    if (state !== 2'd2 || stop !== 1'b0) begin
      nerr++; $display("FAIL play_enter: state %0d stop %b want 2 0", state, stop);
    end
    nvec++;
    address = 18'h00050;
    step();
    if (done !== 1'b0 || state !== 2'd2) begin
      nerr++; $display("FAIL play_mid: done %b state %0d want 0 2", done, state);
    end
    nvec++;
    address = 18'h00100;
    step();
    if (done !== 1'b1) begin nerr++; $display("FAIL play_done: got %b want 1", done); end
    nvec++;
`ifdef AUDIO_CTRL_AUTOLOOP_EN
    if (state !== 2'd3 || stop !== 1'b1) begin
      nerr++; $display("FAIL play_end_state: state %0d stop %b want 3 1", state, stop);
    end
`else
    if (state !== 2'd0 || stop !== 1'b1) begin
      nerr++; $display("FAIL play_end_state: state %0d stop %b want 0 1", state, stop);
    end
`endif
    nvec++;
    address = 18'h0;
    step();
    if (done !== 1'b0) begin nerr++; $display("FAIL done_single: got %b want 0", done); end
    nvec++;
`ifdef AUDIO_CTRL_AUTOLOOP_EN
    if (state !== 2'd2 || stop !== 1'b0) begin
      nerr++; $display("FAIL rewind_play: state %0d stop %b want 2 0", state, stop);
    end
`else
    if (state !== 2'd0) begin nerr++; $display("FAIL idle_hold: got %0d want 0", state); end
`endif
    nvec++;
    press(5'b10000);
    if (state !== 2'd0 || end_addr !== 18'h00100) begin
      nerr++; $display("FAIL stop_idle: state %0d end %h want 0 00100", state, end_addr);
    end
    nvec++;
  endtask

  task automatic test_overshoot();
    address = 18'h0;
    press(5'b00100);
    address = 18'h000FC;
    step();
    if (done !== 1'b0 || state !== 2'd2) begin
      nerr++; $display("FAIL over_pre: done %b state %0d want 0 2", done, state);
    end
    nvec++;
    address = 18'h00104;
    step();
    if (done !== 1'b1) begin nerr++; $display("FAIL over_done: got %b want 1", done); end
    nvec++;
    address = 18'h0;
    step();
    press(5'b10000);
    if (state !== 2'd0) begin nerr++; $display("FAIL over_idle: got %0d want 0", state); end
    nvec++;
  endtask

  task automatic test_speed();
    lrck = 1'b0;
    step();
    press(5'b00010); press(5'b00010); press(5'b00010);
    step(); step();
    if (rate !== 4'd1 || fast !== 1'b0) begin
      nerr++; $display("FAIL spd_hold: rate %0d fast %b want 1 0", rate, fast);
    end
    nvec++;
    lrck = 1'b1;
    step();
    if (rate !== 4'd1) begin nerr++; $display("FAIL spd_hold_rise: got %0d want 1", rate); end
    nvec++;
    step();
    if (rate !== 4'd4 || fast !== 1'b1 || slow !== 1'b0) begin
      nerr++; $display("FAIL spd_fast: rate %0d fast %b slow %b want 4 1 0", rate, fast, slow);
    end
    nvec++;
    lrck = 1'b0;
    press(5'b00011);
    step();
    lrck = 1'b1;
    step(); step();
    if (rate !== 4'd4 || fast !== 1'b1) begin
      nerr++; $display("FAIL spd_both: rate %0d fast %b want 4 1", rate, fast);
    end
    nvec++;
    lrck = 1'b0;
    interp_sw = 1'b1;
    for (int i = 0; i < 10; i++) press(5'b00001);
    lrck = 1'b1;
    step(); step();
    if (rate !== 4'd8 || slow !== 1'b1 || fast !== 1'b0) begin
      nerr++; $display("FAIL spd_slow_sat: rate %0d slow %b fast %b want 8 1 0", rate, slow, fast);
    end
    nvec++;
    if (interp !== 1'b1) begin nerr++; $display("FAIL interp_on: got %b want 1", interp); end
    nvec++;
    interp_sw = 1'b0;
    step();
    if (interp !== 1'b0) begin nerr++; $display("FAIL interp_off: got %b want 0", interp); end
    nvec++;
    lrck = 1'b0;
  endtask

  task automatic test_back_to_back();
    press(5'b11000);
    if (state !== 2'd0 || record !== 1'b0) begin
      nerr++; $display("FAIL stop_rec_coinc: state %0d rec %b want 0 0", state, record);
    end
    nvec++;
    press(5'b01000);
    press(5'b00100);
    if (state !== 2'd1) begin nerr++; $display("FAIL rec_ignore_play: got %0d want 1", state); end
    nvec++;
    address = 18'h00100;
    press(5'b10000);
    address = 18'h0;
    press(5'b00100);
    address = 18'h00020;
    step();
    press(5'b01000);
    if (state !== 2'd0 || stop !== 1'b1) begin
      nerr++; $display("FAIL play_rec_idle: state %0d stop %b want 0 1", state, stop);
    end
    nvec++;
    address = 18'h0;
    step();
    if (state !== 2'd1 || record !== 1'b1 || stop !== 1'b0) begin
      nerr++; $display("FAIL play_rec_rec: state %0d rec %b stop %b want 1 1 0", state, record, stop);
    end
    nvec++;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    if (record !== 1'b0 || stop !== 1'b1) begin
      nerr++; $display("FAIL async_ctrl: rec %b stop %b want 0 1", record, stop);
    end
    nvec++;
    if (end_addr !== 18'd0 || state !== 2'd0) begin
      nerr++; $display("FAIL async_state: end %h state %0d want 0 0", end_addr, state);
    end
    nvec++;
    if (rate !== 4'd1 || slow !== 1'b0) begin
      nerr++; $display("FAIL async_speed: rate %0d slow %b want 1 0", rate, slow);
    end
    nvec++;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_mem_full();
    press(5'b01000);
    address = 18'h3FFFE;
    step();
    if (state !== 2'd1) begin nerr++; $display("FAIL full_pre: got %0d want 1", state); end
    nvec++;
    address = 18'h3FFFF;
    step();
    if (state !== 2'd0 || record !== 1'b0 || end_addr !== 18'h3FFFF) begin
      nerr++; $display("FAIL full_stop: state %0d rec %b end %h want 0 0 3ffff", state, record, end_addr);
    end
    nvec++;
  endtask

  initial begin
    {btn_stop, btn_record, btn_play, btn_faster, btn_slower} = 5'b0;
    interp_sw = 1'b0;
    lrck      = 1'b0;
    address   = 18'h0;
    rst_n     = 1'b0;
    test_reset();
    test_record_play();
    test_overshoot();
    test_speed();
    test_back_to_back();
    test_async_reset();
    test_mem_full();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
